// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter (start, DBIT data bits LSB-first,
// optional even parity, stop). Bit timing comes from a 16x baud s_tick.
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity bit
// between the last data bit and the stop period.
module uart_tx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16   // s_ticks in stop state: 16/24/32 -> 1/1.5/2 stop bits
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((1 << DBIT) - 1);
`endif

  state_t     state_q, state_d;
  logic [4:0] s_q, s_d;      // s_ticks within the current bit
  logic [2:0] n_q, n_d;      // data bit index
  logic [7:0] b_q, b_d;      // outgoing data, shifted right as bits are sent
  logic       tx_q, tx_d;    // registered serial line
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Next-state and next-line-value logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    tx_d         = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    tx_done_tick = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // s_tick is deliberately ignored here: counting starts with the next tick.
        if (tx_start) begin
          state_d  = ST_START;
          b_d      = din;
          s_d      = '0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^(din & DATA_MASK);
`endif
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
              tx_d    = parity_q;
`else
              state_d = ST_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_d  = n_q + 3'd1;
              tx_d = b_q[1];
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            state_d = ST_STOP;
            s_d     = '0;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            // Done pulses while still in stop, so a same-cycle tx_start is ignored.
            state_d      = ST_IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and line register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      b_q      <= b_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx. Two instances: the
// default geometry (DBIT=8, SB_TICK=16) and DBIT=7 with a 32-tick stop.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NI = 2;
  localparam int D0 = 8, SB0 = 16;
  localparam int D1 = 7, SB1 = 32;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       tx_start [NI];
  logic [7:0] din      [NI];
  logic       tx_busy  [NI];
  logic       tx_done  [NI];
  logic       tx_w     [NI];

  uart_tx #(.DBIT(D0), .SB_TICK(SB0)) dut0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din[0]),
    .tx_busy(tx_busy[0]), .tx_done_tick(tx_done[0]), .tx(tx_w[0])
  );

  uart_tx #(.DBIT(D1), .SB_TICK(SB1)) dut1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din[1]),
    .tx_busy(tx_busy[1]), .tx_done_tick(tx_done[1]), .tx(tx_w[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Baud tick: one pulse every tick_per clocks, driven just after the edge.
  int tick_per = 4;
  int tick_cnt = 0;
  always @(posedge clk) begin
    #1;
    tick_cnt = (tick_cnt + 1 >= tick_per) ? 0 : tick_cnt + 1;
    s_tick   = (tick_cnt == 0);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [dut%0d] @cyc %0d: got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dbit_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 0) ? SB0 : SB1;
  endfunction

  // Line value during bit slot k of a frame carrying v (0 = start bit).
  function automatic logic exp_bit(input int i, input logic [7:0] v, input int k);
    int d;
    d = dbit_of(i);
    if (k == 0) return 1'b0;
    if (k <= d) return v[k-1];
    return ($countones(v & 8'((1 << d) - 1)) % 2) == 1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int   exp_done [NI] = '{default: 0};
  int   dones    [NI] = '{default: 0};
  bit   in_frame [NI] = '{default: 1'b0};
  int   m_cnt    [NI] = '{default: 0};
  logic [7:0] cur [NI];
  int   last_done_cyc [NI] = '{default: 0};
  bit   hold_chk  = 1'b0;
  int   hold_seen = 0;

  always @(negedge clk) begin
    int total;
    int k;
    int qs;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        in_frame[i] = 1'b0;
        continue;
      end
      total = 16 * (1 + dbit_of(i) + P) + sb_of(i);
      if (!in_frame[i]) begin
        check("done_outside_frame", i, tx_done[i], 0);
        if (tx_busy[i]) begin
          qs = (i == 0) ? q0.size() : q1.size();
          check("frame_expected", i, (qs != 0), 1);
          if (qs != 0) cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
          in_frame[i] = 1'b1;
          m_cnt[i]    = 0;
          check("start_edge_low", i, tx_w[i], 0);
          if (hold_chk && i == 0) begin
            if (hold_seen > 0) check("back_to_back_gap", i, cyc - last_done_cyc[i], 2);
            hold_seen++;
          end
        end else begin
          check("idle_line_high", i, tx_w[i], 1);
        end
      end
      if (in_frame[i]) begin
        check("busy_in_frame", i, tx_busy[i], 1);
        if (s_tick) begin
          m_cnt[i]++;
          k = (m_cnt[i] - 1) / 16;
          if (((m_cnt[i] - 1) % 16) == 7 && k < 1 + dbit_of(i) + P)
            check($sformatf("bit%0d_of_%02h", k, cur[i]), i, tx_w[i], exp_bit(i, cur[i], k));
          if (m_cnt[i] == 16 * (1 + dbit_of(i) + P) + sb_of(i) / 2)
            check("stop_high", i, tx_w[i], 1);
          if (m_cnt[i] == total) begin
            check("done_at_frame_end", i, tx_done[i], 1);
            dones[i]++;
            last_done_cyc[i] = cyc;
            in_frame[i] = 1'b0;
          end else if (tx_done[i]) begin
            check("early_done", i, tx_done[i], 0);
          end
        end else if (tx_done[i]) begin
          check("done_without_tick", i, tx_done[i], 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tx_busy[i] || in_frame[i]) && n < 3000);
    check("idle_within_budget", i, tx_busy[i], 0);
  endtask

  task automatic push(input int i, input logic [7:0] v);
    if (i == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  // One-cycle tx_start pulse from idle; din is optionally scrambled afterwards.
  task automatic send(input int i, input logic [7:0] v, input bit scramble);
    wait_idle(i);
    @(posedge clk); #1;
    din[i]      = v;
    tx_start[i] = 1'b1;
    push(i, v);
    exp_done[i]++;
    @(posedge clk); #1;
    tx_start[i] = 1'b0;
    if (scramble) din[i] = 8'($urandom);
  endtask

  initial begin
    int n;
    int cnt;
    for (int i = 0; i < NI; i++) begin
      tx_start[i] = 1'b0;
      din[i]      = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_tx", i, tx_w[i], 1);
      check("reset_busy", i, tx_busy[i], 0);
      check("reset_done", i, tx_done[i], 0);
    end

    // 0x55 with a tick every 4th clock.
    tick_per = 4;
    send(0, 8'h55, 1'b0);
    wait_idle(0);

    // tx_start while busy is ignored: only 0x0F goes out.
    send(0, 8'h0F, 1'b0);
    repeat (300) @(posedge clk);
    #1 din[0] = 8'hA3; tx_start[0] = 1'b1;
    @(posedge clk); #1 tx_start[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    check("no_queued_frame", 0, tx_busy[0], 0);

    // Reset during data bit 3 of 0x00.
    wait_idle(0);
    @(posedge clk); #1;
    din[0] = 8'h00; tx_start[0] = 1'b1; push(0, 8'h00);
    @(posedge clk); #1 tx_start[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt[0] < 16 * 4 + 8 && n < 3000);
    check("reached_data_bit3", 0, (m_cnt[0] >= 16 * 4 + 8), 1);
    cnt = dones[0];
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", 0, tx_w[0], 1);
    check("rst_mid_busy", 0, tx_busy[0], 0);
    check("rst_no_done", 0, dones[0], cnt);
    send(0, 8'h81, 1'b1);
    wait_idle(0);

    // tx_start held high: three back-to-back 0xC3 frames.
    hold_chk = 1'b1;
    hold_seen = 0;
    for (int j = 0; j < 3; j++) push(0, 8'hC3);
    exp_done[0] += 3;
    @(posedge clk); #1 din[0] = 8'hC3; tx_start[0] = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 3 && n < 6000) begin
      @(negedge clk);
      n++;
      if (tx_done[0]) cnt++;
    end
    check("held_start_frames", 0, cnt, 3);
    @(posedge clk); #1 tx_start[0] = 1'b0;
    hold_chk = 1'b0;
    wait_idle(0);
    check("held_start_gaps", 0, hold_seen, 3);

    // Parity cases (parity bit checked when compiled in).
    send(0, 8'h07, 1'b1);
    send(0, 8'h03, 1'b1);
    wait_idle(0);

    // Seven-bit, two-stop-bit instance.
    send(1, 8'hFF, 1'b1);
    wait_idle(1);

    // Randomized bytes and tick rates on both instances.
    for (int j = 0; j < 6; j++) begin
      wait_idle(0);
      wait_idle(1);
      tick_per = $urandom_range(1, 4);
      send(j % 2, 8'($urandom), 1'b1);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      check("done_count", i, dones[i], exp_done[i]);
      check("queue_drained", i, (i == 0) ? q0.size() : q1.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not complete, got %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
